step_move_driver: RTL and testbench
===================================

STEP_MOVE_DRIVER -- requirements
Module: step_move_driver

Interface
REQ-001 Parameter CLK_DIV, default 10, clk cycles per motor step; legal range >= 2.
REQ-002 Parameter STEPS_W, default 16, width of the requested step count.
REQ-003 Parameter POS_W, default 16, width of the signed position counter.
REQ-004 Parameter HOLD_EN, default 0; 1 keeps coils energised when idle.
REQ-005 clk  input  1  system clock; the block has one clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_i  input  1  move request; sampled every cycle.
REQ-008 steps_i  input  STEPS_W  number of steps for the move.
REQ-009 dir_i  input  1  1 = forward (position +1 per step), 0 = reverse.
REQ-010 half_i  input  1  1 = half-step mode, 0 = full-step mode.
REQ-011 abort_i  input  1  terminate the current move.
REQ-012 busy_o  output  1  high while a move is in progress.
REQ-013 done_o  output  1  one-cycle pulse when a move completes normally.
REQ-014 pos_o  output  POS_W  signed accumulated position, two's complement.
REQ-015 signal_o  output  4  coil drive pattern {A,B,C,D}.

Function
REQ-016 FSM states: IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 IDLE: start_i=1 and steps_i!=0 -> RUN; steps_i, dir_i and half_i are latched that cycle.
REQ-018 IDLE: start_i=1 and steps_i==0 -> DONE; no step taken, pos_o unchanged.
REQ-019 start_i outside IDLE is ignored; latched parameters do not change mid-move.
REQ-020 busy_o=1 in RUN and DONE, 0 in IDLE; done_o=1 only in DONE.
REQ-021 Divider counter clears on entry to RUN; it produces a step tick when it reaches CLK_DIV-1, then wraps to 0.
REQ-022 First step tick is CLK_DIV cycles after the start_i sample; subsequent ticks are every CLK_DIV cycles.
REQ-023 Each tick: phase index (3 bits, mod 8) changes by +/-1 in half mode or +/-2 in full mode, following the latched direction; remaining count -1; pos_o +/-1 with wrap at POS_W bits.
REQ-024 Phase table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-025 Full mode keeps index parity: even index gives one-coil wave drive; odd index gives two-coil drive.
REQ-026 signal_o = table[index], registered; it changes in the cycle after the tick.
REQ-027 When the tick makes the remaining count 0 -> DONE on the next cycle; done_o pulses once.
REQ-028 abort_i in RUN -> IDLE next cycle; done_o is not pulsed. If abort_i and a tick occur in the same cycle, abort wins: no step is taken and pos_o is unchanged.
REQ-029 abort_i in IDLE or DONE has no effect.
REQ-030 In IDLE, signal_o = 0000 if HOLD_EN=0, else table[index]; in RUN and DONE, signal_o = table[index].
REQ-031 Phase index and pos_o persist across moves; only reset clears them.

Reset
REQ-032 rst_n low forces, immediately and independent of clk: state IDLE, busy_o=0, done_o=0, pos_o=0, phase index 0, divider 0, remaining 0.
REQ-033 signal_o during reset is 0000 if HOLD_EN=0, else 1000.
REQ-034 Reset asserted mid-move discards the move; no done_o pulse follows release.

Verification
REQ-035 CLK_DIV=10, half=1, dir=1, steps=3 -> ticks at +10/+20/+30 cycles; signal_o 1100, 0100, 0110; pos_o=3; done_o one pulse; busy_o falls after it.
REQ-036 Full mode, dir=0, steps=5, from index 0 -> indices 6,4,2,0,6; signal_o 0001, 0010, 0100, 1000, 0001; pos_o decreases by 5 (wraps below 0).
REQ-037 steps_i=0 -> done_o pulses 1 cycle after start_i; signal_o and pos_o unchanged.
REQ-038 abort_i on the same cycle as the 2nd tick of a 4-step move -> pos_o=+1; IDLE next cycle; no done_o; a second start_i mid-move is ignored.
REQ-039 rst_n low during RUN -> outputs take reset values without a clk edge; after release, start_i=1 with steps=1 -> normal move, pos_o=1.
REQ-040 HOLD_EN=1 -> signal_o holds its last pattern in IDLE after a move; HOLD_EN=0 -> 0000 in IDLE.

Source files
------------

// File: rtl/step_move_driver.sv
// ============================================================================
// step_move_driver : stepper-motor move sequencer, half/full step, signed pos
// Revision 1.0
// ============================================================================
`default_nettype none

module step_move_driver #(
  parameter int CLK_DIV = 10,
  parameter int STEPS_W = 16,
  parameter int POS_W   = 16,
  parameter int HOLD_EN = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [STEPS_W-1:0] steps_i,
  input  logic               dir_i,
  input  logic               half_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [POS_W-1:0]   pos_o,
  output logic [3:0]         signal_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             HOLD     = (HOLD_EN != 0);
  localparam logic [3:0]       SIG_RST  = HOLD ? 4'b1000 : 4'b0000;

  function automatic logic [3:0] phase_pat(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic [2:0]         idx_q, idx_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;
  logic [3:0]         sig_q, sig_d;

  logic       tick;
  logic       step_ok;
  logic [2:0] idx_delta;

  assign tick      = (state_q == S_RUN) && (div_q == DIV_LAST);
  // Abort dominates a coincident tick, so no step is taken that cycle.
  assign step_ok   = tick && !abort_i;
  assign idx_delta = half_q ? 3'd1 : 3'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      rem_q   <= '0;
      idx_q   <= 3'd0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      sig_q   <= SIG_RST;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (steps_i != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (abort_i)                               state_d = S_IDLE;
        else if (tick && (rem_q == STEPS_W'(1)))   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d  = '0;
    rem_d  = rem_q;
    idx_d  = idx_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    half_d = half_q;

    if ((state_q == S_IDLE) && start_i) begin
      rem_d  = steps_i;
      dir_d  = dir_i;
      half_d = half_i;
    end

    if ((state_q == S_RUN) && !tick) div_d = div_q + DIV_W'(1);

    if (step_ok) begin
      rem_d = rem_q - STEPS_W'(1);
      idx_d = dir_q ? (idx_q + idx_delta) : (idx_q - idx_delta);
      pos_d = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    end

    // Registered from next-state values so the pattern tracks the step edge.
    sig_d = ((state_d == S_IDLE) && !HOLD) ? 4'b0000 : phase_pat(idx_d);
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  assign pos_o    = pos_q;
  assign signal_o = sig_q;

endmodule

`default_nettype wire

// File: tb/tb_step_move_driver.sv
// ============================================================================
// tb_step_move_driver : directed self-checking bench, HOLD_EN=0 and =1 copies
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_step_move_driver;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] steps_i;
  logic        dir_i;
  logic        half_i;
  logic        abort_i;

  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] pos_a, pos_b;
  logic [3:0]  sig_a, sig_b;

  int n_tests = 0;
  int n_fail  = 0;

  step_move_driver #(.CLK_DIV(10), .STEPS_W(16), .POS_W(16), .HOLD_EN(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .steps_i(steps_i),
    .dir_i(dir_i), .half_i(half_i), .abort_i(abort_i),
    .busy_o(busy_a), .done_o(done_a), .pos_o(pos_a), .signal_o(sig_a)
  );

  step_move_driver #(.CLK_DIV(10), .STEPS_W(16), .POS_W(16), .HOLD_EN(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .steps_i(steps_i),
    .dir_i(dir_i), .half_i(half_i), .abort_i(abort_i),
    .busy_o(busy_b), .done_o(done_b), .pos_o(pos_b), .signal_o(sig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done_a); end
    n_tests++; if (pos_a !== 16'h0000) begin n_fail++; $display("FAIL rst_pos: got %h want 0000", pos_a); end
    n_tests++; if (sig_a !== 4'b0000) begin n_fail++; $display("FAIL rst_sig_nohold: got %b want 0000", sig_a); end
    n_tests++; if (sig_b !== 4'b1000) begin n_fail++; $display("FAIL rst_sig_hold: got %b want 1000", sig_b); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_half_fwd();
    start_i = 1'b1; steps_i = 16'd3; dir_i = 1'b1; half_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL half_busy0: got %b want 1", busy_a); end
    repeat (9) @(negedge clk);
    n_tests++; if (pos_a !== 16'd0 || sig_a !== 4'b1000) begin n_fail++; $display("FAIL half_pre_tick: got pos %h sig %b want 0000 1000", pos_a, sig_a); end
    @(negedge clk);
    n_tests++; if (pos_a !== 16'd1 || sig_a !== 4'b1100) begin n_fail++; $display("FAIL half_tick1: got pos %h sig %b want 0001 1100", pos_a, sig_a); end
    repeat (10) @(negedge clk);
    n_tests++; if (pos_a !== 16'd2 || sig_a !== 4'b0100) begin n_fail++; $display("FAIL half_tick2: got pos %h sig %b want 0002 0100", pos_a, sig_a); end
    repeat (9) @(negedge clk);
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL half_early_done: got %b want 0", done_a); end
    @(negedge clk);
    n_tests++; if (pos_a !== 16'd3 || sig_a !== 4'b0110) begin n_fail++; $display("FAIL half_tick3: got pos %h sig %b want 0003 0110", pos_a, sig_a); end
    n_tests++; if (done_a !== 1'b1 || busy_a !== 1'b1) begin n_fail++; $display("FAIL half_done: got done %b busy %b want 1 1", done_a, busy_a); end
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL half_idle: got done %b busy %b want 0 0", done_a, busy_a); end
    n_tests++; if (sig_a !== 4'b0000) begin n_fail++; $display("FAIL half_idle_sig_nohold: got %b want 0000", sig_a); end
    n_tests++; if (sig_b !== 4'b0110) begin n_fail++; $display("FAIL half_idle_sig_hold: got %b want 0110", sig_b); end
  endtask

  task automatic test_full_rev();
    logic [3:0] exp_sig [5];
    exp_sig[0] = 4'b0001; exp_sig[1] = 4'b0010; exp_sig[2] = 4'b0100;
    exp_sig[3] = 4'b1000; exp_sig[4] = 4'b0001;
    pulse_reset();
    start_i = 1'b1; steps_i = 16'd5; dir_i = 1'b0; half_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (10) @(negedge clk);
      n_tests++; if (sig_a !== exp_sig[k]) begin n_fail++; $display("FAIL full_tick%0d_sig: got %b want %b", k + 1, sig_a, exp_sig[k]); end
    end
    n_tests++; if (pos_a !== 16'hFFFB) begin n_fail++; $display("FAIL full_pos: got %h want fffb", pos_a); end
    n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", done_a); end
    @(negedge clk);
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL full_idle: got busy %b want 0", busy_a); end
  endtask

  task automatic test_zero_steps();
    start_i = 1'b1; steps_i = 16'd0; dir_i = 1'b1; half_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n_tests++; if (done_a !== 1'b1 || busy_a !== 1'b1) begin n_fail++; $display("FAIL zero_done: got done %b busy %b want 1 1", done_a, busy_a); end
    n_tests++; if (pos_a !== 16'hFFFB || sig_b !== 4'b0001) begin n_fail++; $display("FAIL zero_unchanged: got pos %h sig %b want fffb 0001", pos_a, sig_b); end
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got done %b busy %b want 0 0", done_a, busy_a); end
    n_tests++; if (pos_a !== 16'hFFFB || sig_a !== 4'b0000 || sig_b !== 4'b0001) begin n_fail++; $display("FAIL zero_after: got pos %h sig %b/%b want fffb 0000/0001", pos_a, sig_a, sig_b); end
  endtask

  task automatic test_abort();
    bit saw_done;
    pulse_reset();
    start_i = 1'b1; steps_i = 16'd4; dir_i = 1'b1; half_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (5) @(negedge clk);
    start_i = 1'b1; steps_i = 16'd1; dir_i = 1'b0; half_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (pos_a !== 16'd1 || sig_a !== 4'b1100 || busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_tick1: got pos %h sig %b busy %b want 0001 1100 1", pos_a, sig_a, busy_a); end
    repeat (9) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    n_tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy %b done %b want 0 0", busy_a, done_a); end
    n_tests++; if (pos_a !== 16'd1) begin n_fail++; $display("FAIL abort_pos: got %h want 0001", pos_a); end
    n_tests++; if (sig_a !== 4'b0000 || sig_b !== 4'b1100) begin n_fail++; $display("FAIL abort_sig: got %b/%b want 0000/1100", sig_a, sig_b); end
    saw_done = 1'b0;
    abort_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) saw_done = 1'b1;
    end
    abort_i = 1'b0;
    n_tests++; if (saw_done !== 1'b0 || pos_a !== 16'd1) begin n_fail++; $display("FAIL abort_quiet: got activity %b pos %h want 0 0001", saw_done, pos_a); end
  endtask

  task automatic test_reset_midmove();
    start_i = 1'b1; steps_i = 16'd3; dir_i = 1'b1; half_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (13) @(negedge clk);
    n_tests++; if (pos_a !== 16'd2) begin n_fail++; $display("FAIL rstmid_pre: got pos %h want 0002", pos_a); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pos_a !== 16'd0) begin n_fail++; $display("FAIL rstmid_async: got busy %b done %b pos %h want 0 0 0000", busy_a, done_a, pos_a); end
    n_tests++; if (sig_a !== 4'b0000 || sig_b !== 4'b1000) begin n_fail++; $display("FAIL rstmid_sig: got %b/%b want 0000/1000", sig_a, sig_b); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got done %b busy %b want 0 0", done_a, busy_a); end
    start_i = 1'b1; steps_i = 16'd1; dir_i = 1'b1; half_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++; if (pos_a !== 16'd1 || done_a !== 1'b1 || sig_a !== 4'b1100) begin n_fail++; $display("FAIL rstmid_move: got pos %h done %b sig %b want 0001 1 1100", pos_a, done_a, sig_a); end
    @(negedge clk);
    n_tests++; if (busy_a !== 1'b0 || sig_b !== 4'b1100) begin n_fail++; $display("FAIL rstmid_end: got busy %b sig %b want 0 1100", busy_a, sig_b); end
  endtask

  initial begin
    rst_n = 1'b1; start_i = 1'b0; steps_i = 16'd0;
    dir_i = 1'b0; half_i = 1'b0; abort_i = 1'b0;
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_zero_steps();
    test_abort();
    test_reset_midmove();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
